// File: rtl/i2c_slave_rx_if.sv
// Bus and byte-interface bundle for the i2c_slave_rx write-only I2C target.
// The master modport is the side that drives the pins and consumes bytes.
// The slave modport is the receiver itself.
interface i2c_slave_rx_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       addr_hit;
  logic       busy;
  logic       rx_overrun;

  modport master (
    output scl_in, sda_in, rx_ready,
    input  sda_oe, rx_data, rx_valid, addr_hit, busy, rx_overrun
  );

  modport slave (
    input  scl_in, sda_in, rx_ready,
    output sda_oe, rx_data, rx_valid, addr_hit, busy, rx_overrun
  );
endinterface

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target receiver.
// Oversamples SCL/SDA, detects START/STOP, matches a 7-bit address, ACKs
// through an open-drain enable and hands data bytes out on a valid/ready port.
// Optional feature macro: I2C_GEN_CALL_EN (also accept general-call address 0).
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           reset,
  i2c_slave_rx_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s;
  logic                   scl_d1_q, sda_d1_q;
  logic                   scl_rise_q, scl_fall_q, start_q, stop_q;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       ack_q, ack_d;
  logic       phase_q, phase_d;
  logic       sda_oe_q, sda_oe_d;
  logic       addr_hit_q, addr_hit_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_overrun_q, rx_overrun_d;

  logic [7:0] byte_w;
  logic       addr_match;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // sda_d1_q holds the SDA value that was current when the registered edge
  // flags were computed, so it is the bit to sample alongside scl_rise_q.
  assign byte_w = {shift_q, sda_d1_q};

`ifdef I2C_GEN_CALL_EN
  assign addr_match = ~byte_w[0] &
                      ((byte_w[7:1] == SLAVE_ADDR) | (byte_w[7:1] == 7'h00));
`else
  assign addr_match = ~byte_w[0] & (byte_w[7:1] == SLAVE_ADDR);
`endif

  // Pin synchronizers, delay flop and registered edge / START / STOP flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: synchronizers preset to 1 so leaving reset looks like an idle
      // bus rather than a spurious START.
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_d1_q   <= 1'b1;
      sda_d1_q   <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value of
      // its predecessor, which is what makes the shift chain a synchronizer.
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
      scl_d1_q   <= scl_s;
      sda_d1_q   <= sda_s;
      scl_rise_q <= scl_s & ~scl_d1_q;
      scl_fall_q <= ~scl_s & scl_d1_q;
      // Our own ACK pulls SDA, so ignore SDA edges while we are driving.
      start_q    <= scl_s & scl_d1_q & sda_d1_q & ~sda_s & ~sda_oe_q;
      stop_q     <= scl_s & scl_d1_q & ~sda_d1_q & sda_s & ~sda_oe_q;
    end
  end

  // Protocol FSM and output/buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      ack_q        <= 1'b0;
      phase_q      <= 1'b0;
      sda_oe_q     <= 1'b0;
      addr_hit_q   <= 1'b0;
      busy_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      ack_q        <= ack_d;
      phase_q      <= phase_d;
      sda_oe_q     <= sda_oe_d;
      addr_hit_q   <= addr_hit_d;
      busy_q       <= busy_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  // Next-state logic: START/STOP first, then per-state bit handling.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    ack_d        = ack_q;
    phase_d      = phase_q;
    sda_oe_d     = sda_oe_q;
    addr_hit_d   = addr_hit_q;
    busy_d       = busy_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = 1'b0;

    // Consumer handshake; a byte loading this cycle overrides it below.
    if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;

    if (start_q) begin
      state_d    = ST_ADDR;
      cnt_d      = '0;
      shift_d    = '0;
      phase_d    = 1'b0;
      sda_oe_d   = 1'b0;
      addr_hit_d = 1'b0;
      busy_d     = 1'b1;
    end else if (stop_q) begin
      state_d    = ST_IDLE;
      phase_d    = 1'b0;
      sda_oe_d   = 1'b0;
      addr_hit_d = 1'b0;
      busy_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_DATA: begin
          if (scl_rise_q) begin
            shift_d = byte_w[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              cnt_d = '0;
              if (state_q == ST_ADDR) begin
                ack_d   = 1'b1;
                state_d = addr_match ? ST_ADDR_ACK : ST_IGNORE;
              end else begin
                state_d = ST_DATA_ACK;
                if (!rx_valid_q || bus.rx_ready) begin
                  rx_data_d  = byte_w;
                  rx_valid_d = 1'b1;
                  ack_d      = 1'b1;
                end else begin
                  rx_overrun_d = 1'b1;
                  ack_d        = 1'b0;
                end
              end
            end
          end
        end
        // First falling edge ends bit 8 and opens the ACK clock; the second
        // ends the ACK clock and hands the bus back for the next byte.
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall_q) begin
            if (!phase_q) begin
              phase_d  = 1'b1;
              sda_oe_d = ack_q;
              if (state_q == ST_ADDR_ACK) addr_hit_d = 1'b1;
            end else begin
              phase_d  = 1'b0;
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = ST_DATA;
            end
          end
        end
        default: ;  // IDLE and IGNORE only leave on START/STOP
      endcase
    end
  end

  assign bus.sda_oe     = sda_oe_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.addr_hit   = addr_hit_q;
  assign bus.busy       = busy_q;
  assign bus.rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Self-checking bench for i2c_slave_rx: bit-banged I2C master, open-drain
// SDA model, scoreboard of expected bytes popped on each valid/ready handshake.
`timescale 1ns/1ps
module tb_i2c_slave_rx;

  localparam time Q = 100ns;  // quarter SCL bit period (10 clk cycles)

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic rx_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_hs = 0;
  int ovr_cycles = 0;
  int ovr_pulses = 0;
  logic ovr_prev = 1'b0;
  logic oe_seen = 1'b0;
  logic oe_data_bad = 1'b0;
  logic [7:0] exp_q[$];

  i2c_slave_rx_if bus ();

  assign bus.scl_in   = m_scl;
  assign bus.sda_in   = m_sda & ~bus.sda_oe;  // open-drain wired-AND
  assign bus.rx_ready = rx_ready;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5ns clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Passive monitor: scoreboard pops on handshakes, overrun/oe bookkeeping.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_valid && bus.rx_ready) begin
        n_hs++;
        if (exp_q.size() > 0) check("rx_data", bus.rx_data, exp_q.pop_front());
        else check("rx_unexpected_qsize", exp_q.size(), 1);
      end
      if (bus.rx_overrun) ovr_cycles++;
      if (bus.rx_overrun && !ovr_prev) ovr_pulses++;
      ovr_prev = bus.rx_overrun;
      if (bus.sda_oe) oe_seen = 1'b1;
    end
  end

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      #Q m_sda = b[7-i];
      #Q m_scl = 1'b1;
      #Q if (bus.sda_oe) oe_data_bad = 1'b1;
      #Q m_scl = 1'b0;
    end
  endtask

  task automatic ack_clock(output logic acked);
    #Q m_sda = 1'b1;
    #Q m_scl = 1'b1;
    #Q acked = ~bus.sda_in;
    #Q m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    send_bits(b, 8);
    ack_clock(acked);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic ack;
  int hs0, op0, oc0;

  initial begin
    idle(5);
    reset = 1'b0;
    idle(5);
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_addr_hit", bus.addr_hit, 0);

    // 1: matching write, one data byte
    hs0 = n_hs; oe_data_bad = 1'b0;
    i2c_start();
    idle(3);
    check("t1_busy", bus.busy, 1);
    send_byte(8'hA0, ack); check("t1_addr_ack", ack, 1);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, ack); check("t1_data_ack", ack, 1);
    check("t1_addr_hit", bus.addr_hit, 1);
    i2c_stop(); idle(5);
    check("t1_busy_after_stop", bus.busy, 0);
    check("t1_addr_hit_after_stop", bus.addr_hit, 0);
    check("t1_handshakes", n_hs - hs0, 1);
    check("t1_oe_in_data_bits", oe_data_bad, 0);

    // 2: address mismatch
    hs0 = n_hs; oe_seen = 1'b0;
    i2c_start();
    send_byte(8'hA2, ack); check("t2_addr_ack", ack, 0);
    check("t2_addr_hit", bus.addr_hit, 0);
    send_byte(8'hFF, ack); check("t2_data_ack", ack, 0);
    i2c_stop(); idle(5);
    check("t2_oe_seen", oe_seen, 0);
    check("t2_handshakes", n_hs - hs0, 0);

    // 3: read request to our address is refused
    hs0 = n_hs; oe_seen = 1'b0;
    i2c_start();
    send_byte(8'hA1, ack); check("t3_addr_ack", ack, 0);
    send_byte(8'h11, ack); check("t3_data_ack", ack, 0);
    i2c_stop(); idle(5);
    check("t3_oe_seen", oe_seen, 0);
    check("t3_handshakes", n_hs - hs0, 0);

    // 4: consumer stalled, second byte overruns
    rx_ready = 1'b0;
    op0 = ovr_pulses; oc0 = ovr_cycles;
    i2c_start();
    send_byte(8'hA0, ack); check("t4_addr_ack", ack, 1);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, ack); check("t4_b0_ack", ack, 1);
    send_byte(8'hC3, ack); check("t4_b1_ack", ack, 0);
    check("t4_ovr_pulses", ovr_pulses - op0, 1);
    check("t4_ovr_cycles", ovr_cycles - oc0, 1);
    check("t4_rx_valid_held", bus.rx_valid, 1);
    check("t4_rx_data_held", bus.rx_data, 8'h3C);
    i2c_stop(); idle(5);
    check("t4_valid_over_stop", bus.rx_valid, 1);
    rx_ready = 1'b1;
    idle(5);
    check("t4_rx_valid_cleared", bus.rx_valid, 0);

    // 5: repeated START in the middle of a data byte
    hs0 = n_hs; op0 = ovr_pulses;
    i2c_start();
    send_byte(8'hA0, ack); check("t5_addr_ack", ack, 1);
    send_bits(8'hF0, 4);
    i2c_start();
    send_byte(8'hA0, ack); check("t5_addr2_ack", ack, 1);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, ack); check("t5_data_ack", ack, 1);
    i2c_stop(); idle(5);
    check("t5_handshakes", n_hs - hs0, 1);
    check("t5_no_overrun", ovr_pulses - op0, 0);

    // 6: asynchronous reset in the middle of the address ACK
    i2c_start();
    send_bits(8'hA0, 8);
    #Q m_sda = 1'b1;
    #Q m_scl = 1'b1;
    #Q check("t6_oe_before_reset", bus.sda_oe, 1);
    reset = 1'b1;
    #1;
    check("t6_oe_async", bus.sda_oe, 0);
    check("t6_rx_data", bus.rx_data, 0);
    check("t6_rx_valid", bus.rx_valid, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_addr_hit", bus.addr_hit, 0);
    check("t6_rx_overrun", bus.rx_overrun, 0);
    m_scl = 1'b1; m_sda = 1'b1;
    idle(5);
    reset = 1'b0;
    idle(10);
    hs0 = n_hs;
    i2c_start();
    send_byte(8'hA0, ack); check("t6_addr_ack", ack, 1);
    exp_q.push_back(8'h81);
    send_byte(8'h81, ack); check("t6_data_ack", ack, 1);
    i2c_stop(); idle(5);
    check("t6_handshakes", n_hs - hs0, 1);

    // 7: general call address
    hs0 = n_hs;
    i2c_start();
    send_byte(8'h00, ack);
`ifdef I2C_GEN_CALL_EN
    check("t7_gc_addr_ack", ack, 1);
    exp_q.push_back(8'h06);
    send_byte(8'h06, ack); check("t7_gc_data_ack", ack, 1);
    i2c_stop(); idle(5);
    check("t7_handshakes", n_hs - hs0, 1);
`else
    check("t7_gc_addr_ack", ack, 0);
    send_byte(8'h06, ack); check("t7_gc_data_ack", ack, 0);
    i2c_stop(); idle(5);
    check("t7_handshakes", n_hs - hs0, 0);
`endif

    idle(20);
    check("sb_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
